// File: rtl/timer_iv_pkg.sv
`default_nettype none
// ============================================================================
// timer_iv_pkg : TAxIV bus addresses, vector codes and slot-to-code helper
// Rev 1.0
// ============================================================================
package timer_iv_pkg;

  localparam logic [15:0] TA0IV = 16'h012E;
  localparam logic [15:0] TA1IV = 16'h011E;

  localparam logic [15:0] TAIV_NONE  = 16'h0000;
  localparam logic [15:0] TAIV_CCR1  = 16'h0002;
  localparam logic [15:0] TAIV_CCR2  = 16'h0004;
  localparam logic [15:0] TAIV_CCR3  = 16'h0006;
  localparam logic [15:0] TAIV_CCR4  = 16'h0008;
  localparam logic [15:0] TAIV_CCR5  = 16'h000A;
  localparam logic [15:0] TAIV_CCR6  = 16'h000C;
  localparam logic [15:0] TAIV_TAIFG = 16'h000E;

  typedef enum logic {
    SLOT_IDLE     = 1'b0,
    SLOT_INFLIGHT = 1'b1
  } slot_state_e;

  // Slots 0..num_slots-2 are CCR1.., the last slot is always TAIFG.
  function automatic logic [15:0] slot_code(input int slot, input int num_slots);
    if (slot == num_slots - 1) return TAIV_TAIFG;
    case (slot)
      0:       return TAIV_CCR1;
      1:       return TAIV_CCR2;
      2:       return TAIV_CCR3;
      3:       return TAIV_CCR4;
      4:       return TAIV_CCR5;
      5:       return TAIV_CCR6;
      default: return TAIV_NONE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/timer_iv_if.sv
`default_nettype none
// ============================================================================
// timer_iv_if : peripheral bus plus CCM/counter flag wiring of the TAxIV block
// Rev 1.0
// ============================================================================
interface timer_iv_if #(
  parameter int NUM_CC = 3
);
  logic [15:0]       MAB;
  logic [15:0]       MDBwrite;
  logic              MW;
  logic              BW;
  logic              MR;
  logic [15:0]       MDBread;
  logic [NUM_CC-2:0] CCIFG;
  logic [NUM_CC-2:0] CCIE;
  logic              TAIFG;
  logic              TAIE;
  logic [NUM_CC-2:0] CCIFGclr;
  logic              TAIFGclr;
  logic              IRQ;

  modport master (
    output MAB, MDBwrite, MW, BW, MR, CCIFG, CCIE, TAIFG, TAIE,
    input  MDBread, CCIFGclr, TAIFGclr, IRQ
  );

  modport slave (
    input  MAB, MDBwrite, MW, BW, MR, CCIFG, CCIE, TAIFG, TAIE,
    output MDBread, CCIFGclr, TAIFGclr, IRQ
  );
endinterface
`default_nettype wire

// File: rtl/timer_iv_prio.sv
`default_nettype none
// ============================================================================
// timer_iv_prio : fixed-priority encoder, lowest pending slot wins
// Rev 1.0
// ============================================================================
module timer_iv_prio
  import timer_iv_pkg::*;
#(
  parameter int NS = 3
) (
  input  logic [NS-1:0] pend,
  output logic [NS-1:0] winner,
  output logic [15:0]   iv
);

  // Scan from the top down so the lowest index is the last one written.
  always_comb begin
    winner = '0;
    iv     = TAIV_NONE;
    for (int k = NS - 1; k >= 0; k--) begin
      if (pend[k]) begin
        winner    = '0;
        winner[k] = 1'b1;
        iv        = slot_code(k, NS);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/timer_iv.sv
`default_nettype none
// ============================================================================
// timer_iv : Timer_A interrupt vector (TAxIV) with read/write-to-clear flags
// Rev 1.0
// ============================================================================
module timer_iv
  import timer_iv_pkg::*;
#(
  parameter logic [15:0] IVX    = TA0IV,
  parameter int          NUM_CC = 3
) (
  input  logic         MCLK,
  input  logic         reset,
  timer_iv_if.slave    bus
);

  localparam int NS = NUM_CC;

  logic [NS-1:0] pend;
  logic [NS-1:0] winner;
  logic [NS-1:0] take;
  logic [NS-1:0] inflight;
  logic [15:0]   iv;
  logic          addr_hit;
  logic          access;

  assign pend = {bus.TAIFG & bus.TAIE, bus.CCIFG & bus.CCIE} & ~inflight;

  timer_iv_prio #(
    .NS(NS)
  ) u_prio (
    .pend  (pend),
    .winner(winner),
    .iv    (iv)
  );

  assign addr_hit = (bus.MAB[15:1] == IVX[15:1]);
  assign access   = (bus.MR | bus.MW) & addr_hit;
  // winner is all-zero when iv is NONE, so an empty access takes nothing.
  assign take     = winner & {NS{access}};

  for (genvar k = 0; k < NS; k++) begin : g_slot
    slot_state_e state_q;
    slot_state_e state_d;

    always_comb begin
      state_d = SLOT_IDLE;
      if (take[k]) state_d = SLOT_INFLIGHT;
    end

    always_ff @(posedge MCLK) begin
      if (reset) state_q <= SLOT_IDLE;
      else       state_q <= state_d;
    end

    assign inflight[k] = (state_q == SLOT_INFLIGHT);
  end

  // The inflight flop doubles as the clear pulse; gating with reset squashes
  // a pulse whose access was taken just before reset rose.
  assign bus.CCIFGclr = inflight[NS-2:0] & ~{(NS-1){reset}};
  assign bus.TAIFGclr = inflight[NS-1] & ~reset;
  assign bus.IRQ      = (|pend) & ~reset;
  assign bus.MDBread  = (addr_hit && !reset) ? iv : TAIV_NONE;

  logic unused_ok;
  assign unused_ok = ^{bus.MDBwrite, bus.BW, bus.MAB[0]};

endmodule
`default_nettype wire

// File: tb/tb_timer_iv.sv
`default_nettype none
// ============================================================================
// tb_timer_iv : directed + random stimulus, scoreboarded against a slot model
// Rev 1.0
// ============================================================================
module tb_timer_iv;
  import timer_iv_pkg::*;

  localparam int          NUM_CC = 3;
  localparam int          NCC    = NUM_CC - 1;
  localparam logic [15:0] IVX    = TA0IV;

  logic MCLK = 1'b0;
  logic reset;

  timer_iv_if #(.NUM_CC(NUM_CC)) bus ();

  timer_iv #(
    .IVX   (IVX),
    .NUM_CC(NUM_CC)
  ) dut (
    .MCLK (MCLK),
    .reset(reset),
    .bus  (bus)
  );

  always #5 MCLK = ~MCLK;

  typedef struct packed {
    logic [15:0]    mdb;
    logic           irq;
    logic [NCC-1:0] clr;
    logic           tclr;
  } exp_t;

  exp_t exp_q[$];
  exp_t got_e;
  int   vectors     = 0;
  int   miscompares = 0;

  // CCM/counter flags as the surrounding hardware would hold them
  logic [NCC-1:0] m_cc;
  logic           m_ta;
  logic [NCC-1:0] m_clr_prev;
  logic           m_tclr_prev;
  int             m_infl; // slot whose clear is due this cycle, -1 none, NCC = TAIFG

  task automatic cyc(input logic rst, input logic [NCC-1:0] cc_set, input logic [NCC-1:0] cc_en,
                     input logic ta_set, input logic ta_en, input logic mr, input logic mw,
                     input logic bw, input logic [15:0] addr, input logic [15:0] wdata);
    int          win;
    logic [15:0] exp_iv;
    exp_t        e;
    @(posedge MCLK);
    #1;
    m_cc = (m_cc & ~m_clr_prev) | cc_set;
    m_ta = (m_ta & ~m_tclr_prev) | ta_set;
    reset        = rst;
    bus.CCIFG    = m_cc;
    bus.CCIE     = cc_en;
    bus.TAIFG    = m_ta;
    bus.TAIE     = ta_en;
    bus.MR       = mr;
    bus.MW       = mw;
    bus.BW       = bw;
    bus.MAB      = addr;
    bus.MDBwrite = wdata;
    win = -1;
    for (int s = 0; s <= NCC; s++) begin
      logic f;
      logic en;
      f  = (s < NCC) ? m_cc[s] : m_ta;
      en = (s < NCC) ? cc_en[s] : ta_en;
      if (win < 0 && f && en && s != m_infl) win = s;
    end
    exp_iv = (win < 0) ? 16'h0000 : ((win < NCC) ? 16'(2 * (win + 1)) : 16'h000E);
    e.irq  = !rst && (win >= 0);
    e.mdb  = (!rst && addr[15:1] == IVX[15:1]) ? exp_iv : 16'h0000;
    e.clr  = '0;
    e.tclr = 1'b0;
    if (!rst && m_infl >= 0) begin
      if (m_infl < NCC) e.clr[m_infl] = 1'b1;
      else              e.tclr = 1'b1;
    end
    exp_q.push_back(e);
    m_clr_prev  = e.clr;
    m_tclr_prev = e.tclr;
    m_infl = (!rst && (mr || mw) && addr[15:1] == IVX[15:1] && win >= 0) ? win : -1;
  endtask

  always @(negedge MCLK) begin
    if (exp_q.size() > 0) begin
      got_e = exp_q.pop_front();
      vectors++;
      if (bus.MDBread !== got_e.mdb || bus.IRQ !== got_e.irq ||
          bus.CCIFGclr !== got_e.clr || bus.TAIFGclr !== got_e.tclr) begin
        miscompares++;
        $display("FAIL vec%0d @%0t: got MDBread=%h IRQ=%b CCIFGclr=%b TAIFGclr=%b, want %h %b %b %b",
                 vectors, $time, bus.MDBread, bus.IRQ, bus.CCIFGclr, bus.TAIFGclr,
                 got_e.mdb, got_e.irq, got_e.clr, got_e.tclr);
      end
    end
  end

  initial begin
    logic [15:0] a;
    reset = 1'b1;
    bus.MAB = '0; bus.MDBwrite = '0; bus.MW = 1'b0; bus.BW = 1'b0; bus.MR = 1'b0;
    bus.CCIFG = '0; bus.CCIE = '0; bus.TAIFG = 1'b0; bus.TAIE = 1'b0;
    m_cc = '0; m_ta = 1'b0; m_clr_prev = '0; m_tclr_prev = 1'b0; m_infl = -1;

    // reset with flags up but disabled, then a read that must clear nothing
    cyc(1, 2'b11, 2'b00, 0, 0, 0, 0, 0, IVX, 16'h0);
    cyc(1, 2'b00, 2'b00, 0, 0, 0, 0, 0, IVX, 16'h0);
    cyc(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, IVX, 16'h0);
    cyc(0, 2'b00, 2'b00, 0, 0, 1, 0, 0, IVX, 16'h0);
    cyc(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, IVX, 16'h0);

    // single CCR1 flag read and cleared
    m_cc = '0;
    cyc(0, 2'b00, 2'b01, 0, 0, 0, 0, 0, IVX, 16'h0);
    cyc(0, 2'b01, 2'b01, 0, 0, 0, 0, 0, IVX, 16'h0);
    cyc(0, 2'b00, 2'b01, 0, 0, 1, 0, 0, IVX, 16'h0);
    cyc(0, 2'b00, 2'b01, 0, 0, 0, 0, 0, IVX, 16'h0);
    cyc(0, 2'b00, 2'b01, 0, 0, 0, 0, 0, IVX, 16'h0);

    // three back-to-back reads walk the priority chain, fourth sees none
    cyc(0, 2'b11, 2'b11, 1, 1, 0, 0, 0, IVX, 16'h0);
    for (int i = 0; i < 4; i++) cyc(0, 2'b00, 2'b11, 0, 1, 1, 0, 0, IVX, 16'h0);
    cyc(0, 2'b00, 2'b11, 0, 1, 0, 0, 0, IVX, 16'h0);
    cyc(0, 2'b00, 2'b11, 0, 1, 0, 0, 0, IVX, 16'h0);

    // byte write at the high byte address clears TAIFG, data ignored
    m_cc = '0; m_ta = 1'b0;
    cyc(0, 2'b00, 2'b11, 1, 1, 0, 0, 0, IVX + 16'd1, 16'h0);
    cyc(0, 2'b00, 2'b11, 0, 1, 0, 1, 1, IVX + 16'd1, 16'hBEEF);
    cyc(0, 2'b00, 2'b11, 0, 1, 0, 0, 0, IVX, 16'h0);
    cyc(0, 2'b00, 2'b11, 0, 1, 0, 0, 0, IVX, 16'h0);

    // reset right after the access squashes the clear; flag survives
    cyc(0, 2'b01, 2'b01, 0, 0, 0, 0, 0, IVX, 16'h0);
    cyc(0, 2'b00, 2'b01, 0, 0, 1, 0, 0, IVX, 16'h0);
    cyc(1, 2'b00, 2'b01, 0, 0, 0, 0, 0, IVX, 16'h0);
    cyc(0, 2'b00, 2'b01, 0, 0, 0, 0, 0, IVX, 16'h0);
    cyc(0, 2'b00, 2'b01, 0, 0, 0, 0, 0, IVX, 16'h0);

    // off-address accesses with flags pending
    cyc(0, 2'b10, 2'b11, 1, 1, 1, 0, 0, IVX + 16'd2, 16'h0);
    cyc(0, 2'b00, 2'b11, 0, 1, 0, 1, 0, 16'h0160, 16'h1234);
    cyc(0, 2'b00, 2'b11, 0, 1, 0, 0, 0, 16'h0160, 16'h0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [NCC-1:0] cs;
      logic [NCC-1:0] ce;
      cs = '0;
      ce = '0;
      for (int b = 0; b < NCC; b++) begin
        cs[b] = ($urandom_range(0, 3) == 0);
        ce[b] = ($urandom_range(0, 3) != 0);
      end
      case ($urandom_range(0, 3))
        0:       a = IVX;
        1:       a = IVX + 16'd1;
        2:       a = IVX + 16'd2;
        default: a = 16'($urandom);
      endcase
      cyc(($urandom_range(0, 40) == 0), cs, ce, ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 4) == 0), 1'($urandom), a, 16'($urandom));
    end

    cyc(0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 16'h0, 16'h0);
    @(posedge MCLK);
    @(negedge MCLK);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected vectors left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
